// File: rtl/iq_fnt_buf_if.sv
// Fetch-to-decode bundle for the instruction queue: push lanes in, decode window out.
// Carries thermometer-coded lane valids in both directions plus decode's pop count.
// Push is gated by the replicated fnt_ready; decode retires entries by id_pop_cnt.
interface iq_fnt_buf_if #(
  parameter int P_IW    = 1,
  parameter int P_FW    = 1,
  parameter int INSN_DW = 32,
  parameter int PC_W    = 32,
  parameter int EXC_W   = 4,
  parameter int BPU_W   = 8
);
  localparam int IW = 1 << P_IW;
  localparam int FW = 1 << P_FW;

  // Push side (frontend -> queue)
  logic [FW-1:0]              fnt_valid;
  logic [FW-1:0][INSN_DW-1:0] fnt_ins;
  logic [FW-1:0][PC_W-1:0]    fnt_pc;
  logic [FW-1:0][EXC_W-1:0]   fnt_exc;
  logic [FW-1:0][BPU_W-1:0]   fnt_bpu_upd;
  logic [FW-1:0]              fnt_ready;

  // Window side (queue -> decode)
  logic [IW-1:0]              id_valid;
  logic [IW-1:0][INSN_DW-1:0] id_ins;
  logic [IW-1:0][PC_W-1:0]    id_pc;
  logic [IW-1:0][EXC_W-1:0]   id_exc;
  logic [IW-1:0][BPU_W-1:0]   id_bpu_upd;
  logic [P_IW:0]              id_pop_cnt;

  // Environment side: drives pushes and pop count, observes window
  modport master (
    output fnt_valid, fnt_ins, fnt_pc, fnt_exc, fnt_bpu_upd, id_pop_cnt,
    input  fnt_ready, id_valid, id_ins, id_pc, id_exc, id_bpu_upd
  );

  // Queue side
  modport slave (
    input  fnt_valid, fnt_ins, fnt_pc, fnt_exc, fnt_bpu_upd, id_pop_cnt,
    output fnt_ready, id_valid, id_ins, id_pc, id_exc, id_bpu_upd
  );
endinterface

// File: rtl/iq_fnt_buf.sv
// Instruction queue: circular buffer between fetch and decode, FW pushes / up to IW pops per cycle.
// Latency: a pushed entry is visible on the decode window one cycle after the write edge.
// Backpressure: fnt_ready comes from registered count only; a same-cycle pop never raises it.
module iq_fnt_buf #(
  parameter int CONFIG_P_ISSUE_WIDTH = 1,
  parameter int CONFIG_P_FETCH_WIDTH = 1,
  parameter int CONFIG_P_IQ_DEPTH    = 3,
  parameter int NCPU_INSN_DW         = 32,
  parameter int PC_W                 = 32,
  parameter int FNT_EXC_W            = 4,
  parameter int BPU_UPD_W            = 8
) (
  input logic        clk,
  input logic        rst,
  input logic        flush,
  iq_fnt_buf_if.slave io
);
  localparam int IW    = 1 << CONFIG_P_ISSUE_WIDTH;
  localparam int FW    = 1 << CONFIG_P_FETCH_WIDTH;
  localparam int DEPTH = 1 << CONFIG_P_IQ_DEPTH;
  localparam int AW    = CONFIG_P_IQ_DEPTH;
  localparam int CW    = CONFIG_P_IQ_DEPTH + 1;
  localparam int PNW   = CONFIG_P_FETCH_WIDTH + 1;
  localparam int WNW   = CONFIG_P_ISSUE_WIDTH + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] FW_C    = CW'(FW);

  typedef struct packed {
    logic [BPU_UPD_W-1:0]    bpu;
    logic [FNT_EXC_W-1:0]    exc;
    logic [PC_W-1:0]         pc;
    logic [NCPU_INSN_DW-1:0] ins;
  } ent_t;

  ent_t            mem_q [DEPTH];
  ent_t            mem_d [DEPTH];
  ent_t            rd_ent [IW];
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   free_cnt;
  logic            push_en;
  logic [PNW-1:0]  valid_n;
  logic [PNW-1:0]  push_n;
  logic [WNW-1:0]  win_n;

  // Admission: only registered occupancy decides readiness, keeping id_pop_cnt off this path
  always_comb begin
    free_cnt = DEPTH_C - count_q;
    push_en  = (free_cnt >= FW_C);
    valid_n  = '0;
    for (int i = 0; i < FW; i++) begin
      valid_n = valid_n + PNW'(io.fnt_valid[i]);
    end
    push_n = push_en ? valid_n : '0;
  end

  // Payload write: accepted lanes land at consecutive slots from wptr, wrapping mod DEPTH
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < FW; i++) begin
      if (PNW'(i) < push_n) begin
        mem_d[wptr_q + AW'(i)] = '{bpu: io.fnt_bpu_upd[i],
                                   exc: io.fnt_exc[i],
                                   pc:  io.fnt_pc[i],
                                   ins: io.fnt_ins[i]};
      end
    end
  end

  // Payload storage is deliberately left unreset; the pointers define what is live
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and occupancy update; flush overrides any same-cycle push and pop
  always_comb begin
    rptr_d  = rptr_q + AW'(io.id_pop_cnt);
    wptr_d  = wptr_q + AW'(push_n);
    count_d = count_q + CW'(push_n) - CW'(io.id_pop_cnt);
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Decode window: thermometer valid from occupancy, lane i reads slot rptr+i
  always_comb begin
    io.fnt_ready = {FW{push_en}};
    win_n        = '0;
    for (int i = 0; i < IW; i++) begin
      rd_ent[i]        = mem_q[rptr_q + AW'(i)];
      io.id_valid[i]   = (count_q > CW'(i));
      io.id_ins[i]     = rd_ent[i].ins;
      io.id_pc[i]      = rd_ent[i].pc;
      io.id_exc[i]     = rd_ent[i].exc;
      io.id_bpu_upd[i] = rd_ent[i].bpu;
      win_n            = win_n + WNW'(io.id_valid[i]);
    end
  end

  // Push lane valids must be contiguous from lane 0
  a_fnt_valid_thermo: assert property (@(posedge clk) disable iff (!rst)
    ((io.fnt_valid & (io.fnt_valid + 1'b1)) == '0))
    else $error("iq_fnt_buf: non-thermometer fnt_valid %b", io.fnt_valid);

  // Decode may only retire entries that are actually presented
  a_pop_in_window: assert property (@(posedge clk) disable iff (!rst)
    (io.id_pop_cnt <= win_n))
    else $error("iq_fnt_buf: id_pop_cnt %0d exceeds window %0d", io.id_pop_cnt, win_n);
endmodule

// File: doc/iq_fnt_buf.md
# iq_fnt_buf

Instruction queue between the fetch frontend and the decode/issue stage. It accepts up to 2^CONFIG_P_FETCH_WIDTH fetched instructions per cycle with their PC, frontend exception, and BPU-update payload. It presents the oldest up to 2^CONFIG_P_ISSUE_WIDTH entries to decode as a thermometer-valid window. Each cycle it retires the number of entries decode reports as issued on `id_pop_cnt`.

## Interface
- CONFIG_P_ISSUE_WIDTH, 1: log2 of the decode window width IW.
- CONFIG_P_FETCH_WIDTH, 1: log2 of the push width FW.
- CONFIG_P_IQ_DEPTH, 3: log2 of the entry count DEPTH. Must satisfy DEPTH ≥ 2·max(IW,FW).
- Payload widths come from `ncpu64k_config.vh`: `NCPU_INSN_DW`, `PC_W`, `FNT_EXC_W`, `BPU_UPD_W`. One entry is E = the sum of these four widths.
- clk  in  1  Single clock. All state changes on the rising edge.
- rst  in  1  Synchronous, active-low reset. Sampled on the clk rising edge.
- flush  in  1  Discards all entries (pipeline redirect).
- fnt_valid  in  FW  Push lane valids. Must be thermometer-coded from lane 0.
- fnt_ins / fnt_pc / fnt_exc / fnt_bpu_upd  in  FW×field  Push payload. Lane i occupies slice i.
- fnt_ready  out  FW  Replicated ready bit: all bits are 1 iff free entries ≥ FW.
- id_valid  out  IW  Bit i = 1 iff occupancy > i.
- id_ins / id_pc / id_exc / id_bpu_upd  out  IW×field  Payload of the entry at rptr+i (mod DEPTH) on lane i.
- id_pop_cnt  in  P_IW+1  Number of window entries consumed this cycle. Must be 0..popcount(id_valid).

## Operation
- Storage: circular buffer of DEPTH entries, E bits each. Payload RAM/regs are not reset.
- State: rptr and wptr, each CONFIG_P_IQ_DEPTH bits, wrap mod DEPTH. count is CONFIG_P_IQ_DEPTH+1 bits, range 0..DEPTH.
- Push:
  - push_en = fnt_ready[0].
  - push_n = push_en ? popcount(fnt_valid) : 0.
  - Lane i (i < push_n) writes entry wptr+i.
  - wptr ← wptr + push_n.
- Pop:
  - rptr ← rptr + id_pop_cnt.
  - Popped entries are not cleared.
- Occupancy: count ← count + push_n − id_pop_cnt. A push and a pop in the same cycle are both applied.
- fnt_ready:
  - Derived only from registered count: (DEPTH − count) ≥ FW.
  - A same-cycle pop does not raise it; this avoids a combinational path id_pop_cnt → fnt_ready.
- Read window: lane i = entry[rptr+i], a combinational mux from registered state. Payload on lanes with id_valid[i]=0 is don't-care.
- Flush: next state is rptr=wptr=count=0. It dominates any push and pop in the same cycle; the pushed data is discarded.
- Reset (rst=0 at the edge): rptr=wptr=count=0; the same priority as flush.
- Illegal stimulus, flagged by simulation assertions. RTL behaviour is then unspecified:
  - non-thermometer fnt_valid;
  - id_pop_cnt > popcount(id_valid).

## Timing
- Push-to-visible latency is 1 cycle: an entry written at edge N appears on id_valid/id_* after edge N.
- Pop takes effect at the edge. The next window starts at the new rptr in the following cycle.
- Full empty-queue throughput: push FW/cycle and pop ≤ IW/cycle sustained, no bubbles, provided count stays ≤ DEPTH−FW.
- Full boundary: at count > DEPTH−FW, fnt_ready=0 for the whole cycle even if decode pops that cycle. It rises 1 cycle after a pop brings the registered count back to ≤ DEPTH−FW.
- Empty boundary: count=0 gives id_valid=0. A same-cycle push does not bypass to the window.
- Pointer wrap: window and push lanes straddle the DEPTH−1 → 0 boundary transparently.
- Output values during and after reset (rst=0, and the first cycle after rst rises): id_valid=0, fnt_ready=all-ones. id_* payload is X-tolerant.
- Reset or flush mid-operation: the window clears on the next cycle; no stale entry is ever presented as valid.

## Test plan
(DEPTH=8, IW=2, FW=2, `NCPU_INSN_DW`=32)
1. Reset then push ins 0x11,0x22 (pc 0x100,0x104) with id_pop_cnt=0.
   - Next cycle: id_valid=2'b11, id_ins={0x22,0x11}, count=2.
2. From empty, push one entry 0x33.
   - Next cycle: id_valid=2'b01.
   - Drive id_pop_cnt=1 → following cycle: id_valid=2'b00.
3. Push 2/cycle, pop 0, until count=6.
   - fnt_ready=0 while count=7 or 8. With a single-lane push at count=6 giving 7, ready drops.
   - Pop 2 → ready returns the next cycle, not the same cycle.
4. Wrap: advance rptr=wptr=7 then push 0xA,0xB.
   - Window shows 0xA (entry 7) and 0xB (entry 0) in order.
   - Pop 2 → rptr=1.
5. Simultaneous push 2 / pop 1 at count=3 → count=4.
   - Window lane0 = the former lane1 entry.
6. Flush asserted in the same cycle as push 2 and pop 1 at count=4.
   - Next cycle: id_valid=0, count=0, fnt_ready=all-ones.
   - Repeat the same stimulus with rst=0 → same result.
